// File: rtl/phy_rx_pkg.sv
// Shared definitions for the PIPE receive framer: K-code bytes, framing words,
// FSM state encoding and the output FIFO entry layout.
package phy_rx_pkg;

  localparam logic [7:0] K_HPSTART  = 8'hFB;
  localparam logic [7:0] K_DPPSTART = 8'h5C;
  localparam logic [7:0] K_DPPEND   = 8'hFD;
  localparam logic [7:0] K_DPPABORT = 8'h7C;
  localparam logic [7:0] K_END      = 8'hF7;
  localparam logic [7:0] K_SKP      = 8'h3C;

  // Byte 0 sits in bits [7:0], so the trailing F7 lands in the top byte.
  localparam logic [31:0] HPSTART_W  = {K_END, K_HPSTART, K_HPSTART, K_HPSTART};
  localparam logic [31:0] DPPSTART_W = {K_END, K_DPPSTART, K_DPPSTART, K_DPPSTART};
  localparam logic [31:0] DPPEND_W   = {K_END, K_DPPEND, K_DPPEND, K_DPPEND};
  localparam logic [31:0] DPPABORT_W = {K_END, K_DPPABORT, K_DPPABORT, K_DPPABORT};
  localparam logic [31:0] SKP_W      = {4{K_SKP}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HP,
    ST_DPP,
    ST_DISCARD
  } rx_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        kind;
    logic        abort;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  function automatic fifo_entry_t make_entry(input logic [31:0] data, input logic sop,
                                             input logic eop, input logic kind,
                                             input logic abort);
    fifo_entry_t e;
    e.data  = data;
    e.sop   = sop;
    e.eop   = eop;
    e.kind  = kind;
    e.abort = abort;
    return e;
  endfunction

endpackage

// File: rtl/phy_rx_fifo.sv
// Show-ahead synchronous FIFO; a push and a pop in the same cycle both succeed,
// even when full.
module phy_rx_fifo
  import phy_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_entry,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the head is only observed when
  // the FIFO is non-empty, so a reset here would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/phy_rx_framer.sv
// PIPE receive framer: splits the RxData stream into header packets and data
// packet payloads, flags framing errors and buffers words in an output FIFO.
module phy_rx_framer
  import phy_rx_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_DPP_WORDS = 257
) (
  input  logic        phy_pipe_pclk,
  input  logic        phy_pipe_rst_n,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_datak,
  input  logic [2:0]  rx_status,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_kind,
  output logic        out_abort,
  output logic        err_framing,
  output logic        err_overflow,
  input  logic        err_clear
);

  localparam int            CW      = $clog2(MAX_DPP_WORDS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DPP_WORDS);

  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_datak;
  logic [2:0]  in_status;

  rx_state_e     state, state_nx;
  logic [1:0]    hp_cnt, hp_cnt_nx;
  logic [CW-1:0] dpp_cnt, dpp_cnt_nx;
  logic          hold_valid, hold_valid_nx;
  logic [31:0]   hold_data, hold_data_nx;
  logic          dpp_pushed, dpp_pushed_nx;
  logic          abort_pending, abort_pending_nx;
  logic          pending_sop, pending_sop_nx;
  logic          pending_kind, pending_kind_nx;
  logic          framing_nx;
  logic          overflow;

  logic          k_ok, is_skp, is_hps, is_dps, is_dpe, is_dpa, is_data;
  logic          req_push, fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_space, marker_push;
  fifo_entry_t   req_entry, push_entry, head_e;
  logic [ENTRY_W-1:0] fifo_in, fifo_head;

  // Input stage: registering the PIPE bus decouples PHY timing from the decode.
  always_ff @(posedge phy_pipe_pclk or negedge phy_pipe_rst_n) begin
    if (!phy_pipe_rst_n) begin
      in_valid  <= 1'b0;
      in_data   <= '0;
      in_datak  <= '0;
      in_status <= '0;
    end else begin
      in_valid  <= rx_valid;
      in_data   <= rx_data;
      in_datak  <= rx_datak;
      in_status <= rx_status;
    end
  end

  assign k_ok    = in_valid && (in_datak == 4'hF) && (in_status == 3'b000);
  assign is_skp  = k_ok && (in_data == SKP_W);
  assign is_hps  = k_ok && (in_data == HPSTART_W);
  assign is_dps  = k_ok && (in_data == DPPSTART_W);
  assign is_dpe  = k_ok && (in_data == DPPEND_W);
  assign is_dpa  = k_ok && (in_data == DPPABORT_W);
  assign is_data = in_valid && (in_datak == 4'h0) && (in_status == 3'b000);

  assign fifo_pop    = out_ready && !fifo_empty;
  assign fifo_space  = !fifo_full || fifo_pop;
  assign marker_push = abort_pending && fifo_space;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx         = state;
    hp_cnt_nx        = hp_cnt;
    dpp_cnt_nx       = dpp_cnt;
    hold_valid_nx    = hold_valid;
    hold_data_nx     = hold_data;
    dpp_pushed_nx    = dpp_pushed;
    abort_pending_nx = abort_pending;
    pending_sop_nx   = pending_sop;
    pending_kind_nx  = pending_kind;
    framing_nx       = 1'b0;
    overflow         = 1'b0;
    req_push         = 1'b0;
    req_entry        = '0;
    fifo_push        = 1'b0;
    push_entry       = '0;

    case (state)
      ST_IDLE: begin
        if (is_hps) begin
          state_nx  = ST_HP;
          hp_cnt_nx = '0;
        end else if (is_dps) begin
          state_nx      = ST_DPP;
          dpp_cnt_nx    = '0;
          dpp_pushed_nx = 1'b0;
        end
      end
      ST_HP: begin
        if (is_data) begin
          req_push  = 1'b1;
          req_entry = make_entry(in_data, hp_cnt == 2'd0, hp_cnt == 2'd3, 1'b0, 1'b0);
          hp_cnt_nx = hp_cnt + 2'd1;
          if (hp_cnt == 2'd3) state_nx = ST_IDLE;
        end else if (in_valid && !is_skp) begin
          framing_nx = 1'b1;
          req_push   = 1'b1;
          req_entry  = make_entry('0, hp_cnt == 2'd0, 1'b1, 1'b0, 1'b1);
          state_nx   = ST_IDLE;
        end
      end
      ST_DPP: begin
        if (is_data && (dpp_cnt == CNT_MAX)) begin
          framing_nx = 1'b1;
          req_push   = 1'b1;
          req_entry  = make_entry('0, !dpp_pushed, 1'b1, 1'b1, 1'b1);
          state_nx   = ST_DISCARD;
        end else if (is_data) begin
          dpp_cnt_nx    = dpp_cnt + 1'b1;
          hold_valid_nx = 1'b1;
          hold_data_nx  = in_data;
          if (hold_valid) begin
            req_push      = 1'b1;
            req_entry     = make_entry(hold_data, !dpp_pushed, 1'b0, 1'b1, 1'b0);
            dpp_pushed_nx = 1'b1;
          end
        end else if (is_dpe || is_dpa) begin
          req_push = 1'b1;
          state_nx = ST_IDLE;
          if (hold_valid) begin
            req_entry = make_entry(hold_data, !dpp_pushed, 1'b1, 1'b1, is_dpa);
          end else begin
            req_entry  = make_entry('0, 1'b1, 1'b1, 1'b1, 1'b1);
            framing_nx = 1'b1;
          end
        end else if (in_valid && !is_skp) begin
          framing_nx = 1'b1;
          req_push   = 1'b1;
          req_entry  = make_entry('0, !dpp_pushed, 1'b1, 1'b1, 1'b1);
          state_nx   = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (is_dpe || is_dpa) begin
          state_nx = ST_IDLE;
        end else if (is_hps) begin
          state_nx  = ST_HP;
          hp_cnt_nx = '0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // A pending abort marker owns the single write port; a packet word that
    // collides with it is treated exactly like a word hitting a full FIFO.
    if (marker_push) begin
      fifo_push        = 1'b1;
      push_entry       = make_entry('0, pending_sop, 1'b1, pending_kind, 1'b1);
      abort_pending_nx = 1'b0;
    end else if (req_push && fifo_space) begin
      fifo_push  = 1'b1;
      push_entry = req_entry;
    end

    if (req_push && (marker_push || !fifo_space)) begin
      overflow         = 1'b1;
      state_nx         = ST_DISCARD;
      abort_pending_nx = 1'b1;
      if (!abort_pending || marker_push) begin
        pending_sop_nx  = req_entry.sop;
        pending_kind_nx = req_entry.kind;
      end
    end

    if (state_nx != ST_DPP) hold_valid_nx = 1'b0;
  end

  always_ff @(posedge phy_pipe_pclk or negedge phy_pipe_rst_n) begin
    if (!phy_pipe_rst_n) begin
      state         <= ST_IDLE;
      hp_cnt        <= '0;
      dpp_cnt       <= '0;
      hold_valid    <= 1'b0;
      hold_data     <= '0;
      dpp_pushed    <= 1'b0;
      abort_pending <= 1'b0;
      pending_sop   <= 1'b0;
      pending_kind  <= 1'b0;
      err_framing   <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state         <= state_nx;
      hp_cnt        <= hp_cnt_nx;
      dpp_cnt       <= dpp_cnt_nx;
      hold_valid    <= hold_valid_nx;
      hold_data     <= hold_data_nx;
      dpp_pushed    <= dpp_pushed_nx;
      abort_pending <= abort_pending_nx;
      pending_sop   <= pending_sop_nx;
      pending_kind  <= pending_kind_nx;
      err_framing   <= framing_nx;
      err_overflow  <= overflow | (err_overflow & ~err_clear);
    end
  end

  assign fifo_in = push_entry;

  phy_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (phy_pipe_pclk),
    .rst_n      (phy_pipe_rst_n),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Head fields are forced to zero when empty so stale storage never leaks out.
  assign head_e    = fifo_head;
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head_e.data : '0;
  assign out_sop   = out_valid & head_e.sop;
  assign out_eop   = out_valid & head_e.eop;
  assign out_kind  = out_valid & head_e.kind;
  assign out_abort = out_valid & head_e.abort;

endmodule

// File: tb/tb_phy_rx_framer.sv
// Self-checking bench for phy_rx_framer: directed packet scenarios plus
// randomized traffic scored against a packet-level reference model.
module tb_phy_rx_framer;

  localparam logic [31:0] HPS = 32'hF7FBFBFB;
  localparam logic [31:0] DPS = 32'hF75C5C5C;
  localparam logic [31:0] DPE = 32'hF7FDFDFD;
  localparam logic [31:0] DPA = 32'hF77C7C7C;
  localparam logic [31:0] SKP = 32'h3C3C3C3C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic [3:0]  rx_datak = '0;
  logic [2:0]  rx_status = '0;
  logic        out_valid, out_sop, out_eop, out_kind, out_abort;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        err_framing, err_overflow;
  logic        err_clear = 1'b0;
  logic        bp_mode = 1'b0;

  int errors = 0;
  int checks = 0;
  int framing_seen = 0;
  int framing_exp = 0;
  logic [35:0] exp_q[$];
  logic [35:0] out_word;

  always #5 clk = ~clk;

  phy_rx_framer dut (
    .phy_pipe_pclk  (clk),
    .phy_pipe_rst_n (rst_n),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_datak       (rx_datak),
    .rx_status      (rx_status),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_kind       (out_kind),
    .out_abort      (out_abort),
    .err_framing    (err_framing),
    .err_overflow   (err_overflow),
    .err_clear      (err_clear)
  );

  assign out_word = {out_data, out_sop, out_eop, out_kind, out_abort};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] ent(input logic [31:0] d, input logic sop, input logic eop,
                                      input logic kind, input logic abort);
    return {d, sop, eop, kind, abort};
  endfunction

  // Scoreboard: every accepted output word must match the model queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_framing) framing_seen++;
      if (out_valid && out_ready) begin
        check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("out_word", 64'(out_word), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k = 4'h0, input logic [2:0] s = 3'd0);
    if (bp_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      while (!out_ready) begin
        idle(1);
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rx_valid  = 1'b1;
    rx_data   = d;
    rx_datak  = k;
    rx_status = s;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    rx_data   = $urandom;
    rx_datak  = 4'($urandom);
    rx_status = 3'($urandom);
  endtask

  task automatic maybe_noise();
    if ($urandom_range(0, 4) == 0) send(SKP, 4'hF);
    if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
  endtask

  task automatic send_bad();
    case ($urandom_range(0, 3))
      0:       send($urandom, 4'h3);
      1:       send($urandom, 4'h0, 3'($urandom_range(1, 7)));
      2:       send(32'hBCBCBCBC, 4'hF);
      default: send(HPS, 4'hF);
    endcase
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      idle(1);
      n++;
    end
    idle(3);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Reference model works per packet: the expected output words are derived
  // from the packet's shape before it is driven.
  task automatic rand_packet();
    logic [31:0] w [8];
    int sel = $urandom_range(0, 9);
    int n;
    int term;
    int bad;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    if ($urandom_range(0, 3) == 0) send($urandom, 4'h0);
    if (sel < 4) begin
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      for (int p = 1; p <= 4; p++) begin
        if (p == bad) begin
          exp_q.push_back(ent('0, p == 1, 1'b1, 1'b0, 1'b1));
          framing_exp++;
          break;
        end
        exp_q.push_back(ent(w[p-1], p == 1, p == 4, 1'b0, 1'b0));
      end
      send(HPS, 4'hF);
      for (int p = 1; p <= 4; p++) begin
        maybe_noise();
        if (p == bad) begin
          send_bad();
          break;
        end
        send(w[p-1]);
      end
    end else begin
      n    = $urandom_range(0, 6);
      term = $urandom_range(0, 3);
      if (term == 3) begin
        for (int i = 0; i < n - 1; i++) exp_q.push_back(ent(w[i], i == 0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(ent('0, n <= 1, 1'b1, 1'b1, 1'b1));
        framing_exp++;
      end else if (n == 0) begin
        exp_q.push_back(ent('0, 1'b1, 1'b1, 1'b1, 1'b1));
        framing_exp++;
      end else begin
        for (int i = 0; i < n; i++)
          exp_q.push_back(ent(w[i], i == 0, i == n - 1, 1'b1, (term == 2) && (i == n - 1)));
      end
      send(DPS, 4'hF);
      for (int i = 0; i < n; i++) begin
        maybe_noise();
        send(w[i]);
      end
      maybe_noise();
      if (term == 3)      send_bad();
      else if (term == 2) send(DPA, 4'hF);
      else                send(DPE, 4'hF);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    idle(2);
    check("reset_outputs",
          {out_valid, out_sop, out_eop, out_kind, out_abort, err_framing, err_overflow, out_data}, 0);
    rst_n = 1'b1;
    idle(2);

    // Header packet with first-word latency.
    out_ready = 1'b1;
    exp_q.push_back(ent(32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ent(32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ent(32'h33333333, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ent(32'h44444444, 1'b0, 1'b1, 1'b0, 1'b0));
    send(HPS, 4'hF);
    send(32'h11111111);
    @(negedge clk);
    check("hp_latency_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("hp_latency_n1", {out_valid, out_data}, {1'b1, 32'h11111111});
    #1;
    send(32'h22222222);
    send(32'h33333333);
    send(32'h44444444);
    drain("drain_hp");

    // Data packet ending with DPPEND.
    exp_q.push_back(ent(32'hA0000001, 1'b1, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(ent(32'hA0000002, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(ent(32'hA0000003, 1'b0, 1'b1, 1'b1, 1'b0));
    send(DPS, 4'hF);
    send(32'hA0000001);
    send(32'hA0000002);
    send(32'hA0000003);
    send(DPE, 4'hF);
    drain("drain_dpp_end");

    // Data packet ending with DPPABORT: no framing error expected.
    exp_q.push_back(ent(32'hB0000001, 1'b1, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(ent(32'hB0000002, 1'b0, 1'b1, 1'b1, 1'b1));
    send(DPS, 4'hF);
    send(32'hB0000001);
    send(32'hB0000002);
    send(DPA, 4'hF);
    drain("drain_dpp_abort");
    check("dpp_abort_no_framing", 64'(framing_seen), 64'(framing_exp));

    // Bad status on the second header word.
    exp_q.push_back(ent(32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ent('0, 1'b0, 1'b1, 1'b0, 1'b1));
    framing_exp++;
    send(HPS, 4'hF);
    send(32'h11111111);
    send(32'h22222222, 4'h0, 3'b100);
    send(32'h33333333);
    send(32'h44444444);
    drain("drain_hp_status");
    check("hp_status_framing", 64'(framing_seen), 64'(framing_exp));

    // Backpressure overflow on a 10-word data packet.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(ent(32'hC0000000 + 32'(i), i == 1, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(ent('0, 1'b0, 1'b1, 1'b1, 1'b1));
    send(DPS, 4'hF);
    for (int i = 1; i <= 10; i++) send(32'hC0000000 + 32'(i));
    send(DPE, 4'hF);
    idle(2);
    check("overflow_set", 64'(err_overflow), 64'd1);
    out_ready = 1'b1;
    drain("drain_overflow");
    check("overflow_sticky", 64'(err_overflow), 64'd1);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    check("overflow_cleared", 64'(err_overflow), 64'd0);

    // Length overrun: word MAX_DPP_WORDS+1 aborts the packet.
    for (int i = 1; i <= 256; i++) exp_q.push_back(ent(32'hD0000000 + 32'(i), i == 1, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(ent('0, 1'b0, 1'b1, 1'b1, 1'b1));
    framing_exp++;
    send(DPS, 4'hF);
    for (int i = 1; i <= 258; i++) send(32'hD0000000 + 32'(i));
    send(DPE, 4'hF);
    drain("drain_overrun");
    check("overrun_framing", 64'(framing_seen), 64'(framing_exp));

    // Reset mid-packet, then a clean header packet.
    out_ready = 1'b0;
    send(DPS, 4'hF);
    send(32'hE0000001);
    send(32'hE0000002);
    send(32'hE0000003);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", {out_valid, out_data, err_framing, err_overflow}, 0);
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back(ent(32'hF0000000 + 32'(i), i == 1, i == 4, 1'b0, 1'b0));
    send(HPS, 4'hF);
    for (int i = 1; i <= 4; i++) send(32'hF0000000 + 32'(i));
    drain("drain_after_reset");

    // Randomized traffic with light backpressure.
    bp_mode = 1'b1;
    repeat (80) begin
      rand_packet();
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    bp_mode = 1'b0;
    out_ready = 1'b1;
    drain("drain_random");
    check("random_framing", 64'(framing_seen), 64'(framing_exp));
    check("random_no_overflow", 64'(err_overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
